ram1536_port_arbiter: RTL and testbench

- Sequences and shares the byte-wide 1536x8 block-RAM macro between the instruction-fetch port and the load/store data port of the CPU.
- Converts 8/16/32-bit little-endian requests into serial byte reads and writes on the RAM's single read port and single write port.
- Round-robin arbitration between the two requesters.
- Sits between the fetch/LSU stages and the RAM wrapper; one clock drives both RCLK and WCLK.

---
 rtl/ram1536_port_arbiter_if.sv | 63 ++++++
 rtl/ram1536_port_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_ram1536_port_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram1536_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram1536_port_arbiter_if
//
// Bundles the two requester ports (instruction fetch, load/store data) and
// the byte-wide RAM read/write ports of ram1536_port_arbiter.
//
//   fetch port : if_req, if_addr -> if_ready, if_valid, if_rdata, if_err
//   data port  : d_req, d_we, d_size, d_addr, d_wdata
//                -> d_ready, d_valid, d_rdata, d_err
//   RAM side   : ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata <- ram_rdata
//
// Modports:
//   master : the surroundings of the arbiter (CPU stages and RAM wrapper)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface ram1536_port_arbiter_if #(
    parameter int ADDR_W = 11
);
    // Fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_valid;
    logic [31:0]       if_rdata;
    logic              if_err;

    // Load/store port
    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ready;
    logic              d_valid;
    logic [31:0]       d_rdata;
    logic              d_err;

    // RAM macro ports
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [7:0]        ram_rdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;

    modport master (
        output if_req, if_addr,
        input  if_ready, if_valid, if_rdata, if_err,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_ready, d_valid, d_rdata, d_err,
        input  ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata,
        output ram_rdata
    );

    modport slave (
        input  if_req, if_addr,
        output if_ready, if_valid, if_rdata, if_err,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_ready, d_valid, d_rdata, d_err,
        output ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata,
        input  ram_rdata
    );
endinterface

// File: rtl/ram1536_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram1536_port_arbiter
//
// Shares the byte-wide 1536x8 block RAM between the fetch port and the
// load/store port. Each 8/16/32-bit little-endian request is turned into a
// sequence of single-byte RAM accesses; the two requesters are arbitrated
// round-robin.
//
// Ports:
//   clk   : single clock, also drives RAM RCLK/WCLK
//   reset : synchronous, active-high
//   bus   : ram1536_port_arbiter_if.slave (fetch, data and RAM ports)
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses (and misaligned fetches) are
//               granted, skip the RAM entirely, and complete the next cycle
//               with err=1 and rdata=0.
//   undefined : misaligned accesses run byte-serially like aligned ones.
// ---------------------------------------------------------------------------
module ram1536_port_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int RAM_TOP = 1536
) (
    input logic                         clk,
    input logic                         reset,
    ram1536_port_arbiter_if.slave       bus
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_e;

    localparam logic [ADDR_W:0] TOP = (ADDR_W + 1)'(RAM_TOP);

    state_e            state_q, state_d;
    logic              port_q, port_d;            // owner of the transaction: 1 = data
    logic              last_data_q, last_data_d;  // last grant went to data
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        n_q, n_d;                  // byte count 1/2/4
    logic [2:0]        i_q, i_d;                  // byte index
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              phase_q, phase_d;          // RD: 0 = cycle A, 1 = cycle B
    logic [31:0]       rbuf_q, rbuf_d;
    logic              err_q, err_d;

    logic              if_valid_q, if_valid_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic              if_err_q, if_err_d;
    logic              d_valid_q, d_valid_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;

    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Current byte address wraps modulo 2^ADDR_W.
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_oor;
    logic              last_byte;
    logic [4:0]        lane_pos;

    assign cur_addr  = addr_q + ADDR_W'(i_q);
    assign cur_oor   = {1'b0, cur_addr} >= TOP;
    assign last_byte = (i_q == n_q - 3'd1);
    assign lane_pos  = {i_q[1:0], 3'b000};

    // Round-robin: on a tie the port not granted last time wins. Ready is
    // suppressed during reset so no request is reported accepted then dropped.
    logic              gnt_d, gnt_f;
    logic [ADDR_W-1:0] sel_addr;
    logic [2:0]        sel_n;
    logic              misalign;

    assign gnt_d    = !reset && (state_q == IDLE) && bus.d_req
                      && (!bus.if_req || !last_data_q);
    assign gnt_f    = !reset && (state_q == IDLE) && bus.if_req && !gnt_d;
    assign sel_addr = gnt_d ? bus.d_addr : bus.if_addr;
    assign sel_n    = gnt_d ? size_to_n(bus.d_size) : 3'd4;

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((sel_n == 3'd2) && sel_addr[0])
                   || ((sel_n == 3'd4) && (sel_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    logic [7:0]  lane;
    logic [31:0] rd_word;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        last_data_d = last_data_q;
        addr_d      = addr_q;
        n_d         = n_q;
        i_d         = i_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        phase_d     = phase_q;
        rbuf_d      = rbuf_q;
        err_d       = err_q;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = if_err_q;
        d_valid_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;
        lane        = cur_oor ? 8'h00 : bus.ram_rdata;
        rd_word     = rbuf_q;

        case (state_q)
            IDLE: begin
                if (gnt_d || gnt_f) begin
                    port_d      = gnt_d;
                    last_data_d = gnt_d;
                    addr_d      = sel_addr;
                    n_d         = sel_n;
                    we_d        = gnt_d && bus.d_we;
                    wdata_d     = bus.d_wdata;
                    i_d         = 3'd0;
                    phase_d     = 1'b0;
                    rbuf_d      = '0;
                    err_d       = 1'b0;
                    if (misalign) begin
                        // Trapped access: complete next cycle without touching RAM.
                        if (gnt_d) begin
                            d_valid_d = 1'b1;
                            d_rdata_d = '0;
                            d_err_d   = 1'b1;
                        end else begin
                            if_valid_d = 1'b1;
                            if_rdata_d = '0;
                            if_err_d   = 1'b1;
                        end
                    end else begin
                        state_d = (gnt_d && bus.d_we) ? WR : RD;
                    end
                end
            end

            RD: begin
                // The RAM output mux follows the live RADDR/RE, so the address
                // is held for a second cycle before the byte is taken.
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    rd_word[lane_pos +: 8] = lane;
                    rbuf_d  = rd_word;
                    err_d   = err_q || cur_oor;
                    phase_d = 1'b0;
                    i_d     = i_q + 3'd1;
                    if (last_byte) begin
                        state_d = IDLE;
                        if (port_q) begin
                            d_valid_d = 1'b1;
                            d_rdata_d = rd_word;
                            d_err_d   = err_q || cur_oor;
                        end else begin
                            if_valid_d = 1'b1;
                            if_rdata_d = rd_word;
                            if_err_d   = err_q || cur_oor;
                        end
                    end
                end
            end

            WR: begin
                err_d = err_q || cur_oor;
                i_d   = i_q + 3'd1;
                if (last_byte) begin
                    state_d   = IDLE;
                    d_valid_d = 1'b1;
                    d_rdata_d = '0;
                    d_err_d   = err_q || cur_oor;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            port_q      <= 1'b0;
            last_data_q <= 1'b0;
            addr_q      <= '0;
            n_q         <= 3'd0;
            i_q         <= 3'd0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            phase_q     <= 1'b0;
            rbuf_q      <= '0;
            err_q       <= 1'b0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            d_valid_q   <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            last_data_q <= last_data_d;
            addr_q      <= addr_d;
            n_q         <= n_d;
            i_q         <= i_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            phase_q     <= phase_d;
            rbuf_q      <= rbuf_d;
            err_q       <= err_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            d_valid_q   <= d_valid_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign bus.if_ready  = gnt_f;
    assign bus.d_ready   = gnt_d;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;

    // Out-of-range write bytes still take their cycle but never strobe WE.
    assign bus.ram_re    = (state_q == RD);
    assign bus.ram_raddr = cur_addr;
    assign bus.ram_we    = (state_q == WR) && !cur_oor;
    assign bus.ram_waddr = cur_addr;
    assign bus.ram_wdata = wdata_q[lane_pos +: 8];

endmodule

// File: tb/tb_ram1536_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram1536_port_arbiter
//
// Directed bench for ram1536_port_arbiter with a behavioural banked RAM:
// each 512-byte bank registers its read data on RE, and the output mux
// follows the live RE/RADDR[10:9], like the real macro.
// ---------------------------------------------------------------------------
module tb_ram1536_port_arbiter;

    localparam int ADDR_W = 11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_init = 1'b1;

    always #5 clk = ~clk;

    ram1536_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    ram1536_port_arbiter #(.ADDR_W(ADDR_W), .RAM_TOP(1536)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model, preloaded while mem_init is high.
    logic [7:0] mem    [0:2047];
    logic [7:0] bank_q [0:3];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < 2048; a++) mem[a] <= 8'h00;
            mem[11'h000] <= 8'h77;
            mem[11'h001] <= 8'h9C;
            mem[11'h002] <= 8'h01;
            mem[11'h003] <= 8'h02;
            mem[11'h004] <= 8'h03;
            mem[11'h005] <= 8'h04;
            mem[11'h5FE] <= 8'h5A;
            mem[11'h5FF] <= 8'hA5;
            mem[11'h600] <= 8'hAA;
            mem[11'h601] <= 8'hBB;
        end else begin
            if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
            if (bus.ram_re) bank_q[bus.ram_raddr[10:9]] <= mem[bus.ram_raddr];
        end
    end

    assign bus.ram_rdata = bus.ram_re ? bank_q[bus.ram_raddr[10:9]] : 8'h00;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One transaction, starting mid-cycle (after a negedge). lat is the number
    // of cycles from the grant to the valid pulse; exp_bus is the number of
    // cycles in between that show ram_re or ram_we.
    task automatic txn(input string tag, input logic fetch, input logic we,
                       input logic [1:0] size, input logic [10:0] addr,
                       input logic [31:0] wdata, input int lat, input int exp_bus,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input logic chk_rdata);
        int early;
        int busy;
        early = 0;
        busy  = 0;
        if (fetch) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.d_req   = 1'b1;
            bus.d_we    = we;
            bus.d_size  = size;
            bus.d_addr  = addr;
            bus.d_wdata = wdata;
        end
        #1;
        check({tag, ".ready"}, fetch ? bus.if_ready : bus.d_ready, 32'd1);
        @(posedge clk);
        #1;
        if (fetch) bus.if_req = 1'b0;
        else       bus.d_req  = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            #1;
            if (c < lat) begin
                if (fetch ? bus.if_valid : bus.d_valid) early++;
                if (bus.ram_re || bus.ram_we) busy++;
            end
        end
        check({tag, ".valid"}, fetch ? bus.if_valid : bus.d_valid, 32'd1);
        check({tag, ".err"}, fetch ? bus.if_err : bus.d_err, {31'd0, exp_err});
        if (chk_rdata) check({tag, ".rdata"}, fetch ? bus.if_rdata : bus.d_rdata, exp_rdata);
        check({tag, ".early_valid"}, early, 32'd0);
        check({tag, ".ram_cycles"}, busy, exp_bus);
    endtask

    initial begin
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_size  = 2'b00;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        // Reset: requests asserted but nothing may be accepted.
        repeat (2) @(negedge clk);
        mem_init    = 1'b0;
        bus.if_req  = 1'b1;
        bus.d_req   = 1'b1;
        #1;
        check("rst.if_ready", bus.if_ready, 32'd0);
        check("rst.d_ready", bus.d_ready, 32'd0);
        check("rst.valids", {bus.if_valid, bus.d_valid}, 32'd0);
        check("rst.ram_en", {bus.ram_re, bus.ram_we}, 32'd0);
        check("rst.rdata", bus.if_rdata | bus.d_rdata, 32'd0);
        check("rst.err", {bus.if_err, bus.d_err}, 32'd0);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        reset      = 1'b0;

        // Word store then load at 0x010.
        @(negedge clk);
        txn("st_w", 1'b0, 1'b1, 2'b10, 11'h010, 32'h11223344, 5, 4, 32'h0, 1'b0, 1'b0);
        check("st_w.mem", {mem[11'h013], mem[11'h012], mem[11'h011], mem[11'h010]}, 32'h11223344);
        @(negedge clk);
        txn("ld_w", 1'b0, 1'b0, 2'b10, 11'h010, 32'h0, 9, 8, 32'h11223344, 1'b0, 1'b1);

        // Half across the bank0/bank1 boundary; only the low two bytes are stored.
        @(negedge clk);
        txn("st_h", 1'b0, 1'b1, 2'b01, 11'h1FF, 32'h1234BEEF, 3, 2, 32'h0, 1'b0, 1'b0);
        check("st_h.mem", {8'h00, mem[11'h201], mem[11'h200], mem[11'h1FF]}, 32'h0000BEEF);
        @(negedge clk);
        txn("ld_h", 1'b0, 1'b0, 2'b01, 11'h1FF, 32'h0, 5, 4, 32'h0000BEEF, 1'b0, 1'b1);
        @(negedge clk);
        txn("ld_b", 1'b0, 1'b0, 2'b00, 11'h1FF, 32'h0, 3, 2, 32'h000000EF, 1'b0, 1'b1);

        // Size 11 behaves as a word.
        @(negedge clk);
        txn("st_s3", 1'b0, 1'b1, 2'b11, 11'h030, 32'hA1B2C3D4, 5, 4, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        txn("ld_s3", 1'b0, 1'b0, 2'b11, 11'h030, 32'h0, 9, 8, 32'hA1B2C3D4, 1'b0, 1'b1);

        // Fetch.
        @(negedge clk);
        txn("if_w", 1'b1, 1'b0, 2'b10, 11'h010, 32'h0, 9, 8, 32'h11223344, 1'b0, 1'b1);

        // Out-of-range bytes.
        @(negedge clk);
        txn("ld_oor", 1'b0, 1'b0, 2'b10, 11'h5FE, 32'h0, 9, 8, 32'h0000A55A, 1'b1, 1'b1);
        @(negedge clk);
        txn("if_oor", 1'b1, 1'b0, 2'b10, 11'h5FE, 32'h0, 9, 8, 32'h0000A55A, 1'b1, 1'b1);
        @(negedge clk);
        txn("st_oor", 1'b0, 1'b1, 2'b00, 11'h7FF, 32'h0000005C, 2, 0, 32'h0, 1'b1, 1'b0);
        check("st_oor.mem", {24'h0, mem[11'h7FF]}, 32'h0);
        @(negedge clk);
        txn("ld_wrap", 1'b0, 1'b0, 2'b01, 11'h7FF, 32'h0, 5, 4, 32'h00007700, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        check("hold.d_valid", bus.d_valid, 32'd0);
        check("hold.d_err", bus.d_err, 32'd1);
        check("hold.d_rdata", bus.d_rdata, 32'h00007700);

        // Misaligned accesses.
`ifdef MISALIGN_TRAP_EN
        @(negedge clk);
        txn("ld_mis", 1'b0, 1'b0, 2'b10, 11'h002, 32'h0, 1, 0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        txn("ld_mis_h", 1'b0, 1'b0, 2'b01, 11'h003, 32'h0, 1, 0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        txn("if_mis", 1'b1, 1'b0, 2'b10, 11'h001, 32'h0, 1, 0, 32'h0, 1'b1, 1'b1);
`else
        @(negedge clk);
        txn("ld_mis", 1'b0, 1'b0, 2'b10, 11'h002, 32'h0, 9, 8, 32'h04030201, 1'b0, 1'b1);
        @(negedge clk);
        txn("ld_mis_h", 1'b0, 1'b0, 2'b01, 11'h003, 32'h0, 5, 4, 32'h00000302, 1'b0, 1'b1);
        @(negedge clk);
        txn("if_mis", 1'b1, 1'b0, 2'b10, 11'h001, 32'h0, 9, 8, 32'h0302019C, 1'b0, 1'b1);
`endif

        // Arbitration from reset with both requesters held.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 11'h010;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_size  = 2'b00;
        bus.d_addr  = 11'h1FF;
        #1;
        check("arb0.d_ready", bus.d_ready, 32'd1);
        check("arb0.if_ready", bus.if_ready, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("arb1.d_valid", bus.d_valid, 32'd1);
        check("arb1.d_rdata", bus.d_rdata, 32'h000000EF);
        check("arb1.if_ready", bus.if_ready, 32'd1);
        check("arb1.d_ready", bus.d_ready, 32'd0);
        repeat (9) @(negedge clk);
        #1;
        check("arb2.if_valid", bus.if_valid, 32'd1);
        check("arb2.if_rdata", bus.if_rdata, 32'h11223344);
        check("arb2.d_ready", bus.d_ready, 32'd1);
        check("arb2.if_ready", bus.if_ready, 32'd0);
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("arb3.d_valid", bus.d_valid, 32'd1);
        check("arb3.d_rdata", bus.d_rdata, 32'h000000EF);
        check("arb3.if_valid", bus.if_valid, 32'd0);
        check("arb3.if_rdata_hold", bus.if_rdata, 32'h11223344);

        // Reset during the third byte of a word store.
        @(negedge clk);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_size  = 2'b10;
        bus.d_addr  = 11'h020;
        bus.d_wdata = 32'hCAFEF00D;
        #1;
        check("abort.ready", bus.d_ready, 32'd1);
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("abort.byte2_we", bus.ram_we, 32'd1);
        check("abort.byte2_addr", {21'd0, bus.ram_waddr}, 32'h022);
        check("abort.byte2_data", {24'd0, bus.ram_wdata}, 32'h0FE);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("abort.ram_en", {bus.ram_re, bus.ram_we}, 32'd0);
        check("abort.d_valid", bus.d_valid, 32'd0);
        reset = 1'b0;
        txn("post_rst", 1'b0, 1'b0, 2'b00, 11'h010, 32'h0, 3, 2, 32'h00000044, 1'b0, 1'b1);
        check("abort.mem_byte3", {24'd0, mem[11'h023]}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
